// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg
// Shared definitions for the pipeline hazard controller: FSM state
// encodings, the x0 register address and the default event counter width.
package hazard_stall_ctrl_pkg;

   typedef enum logic {
      HZD_RUN   = 1'b0,
      HZD_FLUSH = 1'b1
   } hzd_state_e;

   localparam logic [4:0] HZD_X0 = 5'd0;

   localparam int HZD_CNT_W_DEF = 16;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if
// Bundles the pipeline-side hazard information (ID source fields, ID/EX and
// EX/MEM destination state, redirect) and the enable/bubble controls that
// the hazard controller returns to the PC and pipeline registers.
//   master : pipeline side, drives hazard info and consumes controls
//   slave  : hazard controller, consumes hazard info and drives controls
interface hazard_stall_ctrl_if;

   logic [4:0] Rs1_addr_HZD;
   logic [4:0] Rs2_addr_HZD;
   logic       Rs1_used_HZD;
   logic       Rs2_used_HZD;
   logic [4:0] Rd_IDEX_HZD;
   logic       RegWrite_IDEX_HZD;
   logic       valid_IDEX_HZD;
   logic [4:0] Rd_EXMEM_HZD;
   logic       RegWrite_EXMEM_HZD;
   logic       valid_EXMEM_HZD;
   logic       Redirect_HZD;

   logic       en_PC_HZD;
   logic       en_IFID_HZD;
   logic       NOP_IFID_HZD;
   logic       NOP_IDEX_HZD;
   logic       NOP_EXMEM_HZD;

   modport master (
      output Rs1_addr_HZD, Rs2_addr_HZD, Rs1_used_HZD, Rs2_used_HZD,
             Rd_IDEX_HZD, RegWrite_IDEX_HZD, valid_IDEX_HZD,
             Rd_EXMEM_HZD, RegWrite_EXMEM_HZD, valid_EXMEM_HZD,
             Redirect_HZD,
      input  en_PC_HZD, en_IFID_HZD, NOP_IFID_HZD, NOP_IDEX_HZD, NOP_EXMEM_HZD
   );

   modport slave (
      input  Rs1_addr_HZD, Rs2_addr_HZD, Rs1_used_HZD, Rs2_used_HZD,
             Rd_IDEX_HZD, RegWrite_IDEX_HZD, valid_IDEX_HZD,
             Rd_EXMEM_HZD, RegWrite_EXMEM_HZD, valid_EXMEM_HZD,
             Redirect_HZD,
      output en_PC_HZD, en_IFID_HZD, NOP_IFID_HZD, NOP_IDEX_HZD, NOP_EXMEM_HZD
   );

endinterface

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// hzd_sat_counter
// Saturating up-counter used for performance-debug event counts. Holds at
// all-ones instead of wrapping.
//   clk_HZD   : clock, rising edge
//   rst_n_HZD : asynchronous active-low reset, clears the count
//   inc       : increment enable
//   cnt       : current count
module hzd_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_HZD,
   input  logic         rst_n_HZD,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk_HZD or negedge rst_n_HZD) begin
      if (!rst_n_HZD) begin
         cnt <= '0;
      end else if (inc && (cnt != {W{1'b1}})) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// Hazard controller for the 5-stage core (no forwarding, write-first
// register file). Freezes PC and IF/ID with a bubble into ID/EX while a
// RAW producer sits in ID/EX or EX/MEM, and on a taken branch/jump flushes
// IF/ID, ID/EX and EX/MEM, optionally holding IF/ID in NOP for EXTRA_FLUSH
// further cycles. Control outputs are Mealy (combinational from inputs and
// state) so they act at the same edge the pipeline registers sample.
//
// Ports:
//   clk_HZD        : core clock
//   rst_n_HZD      : asynchronous active-low reset
//   hzd            : hazard info in / enable and bubble controls out
//   stall_cnt_HZD  : saturating count of data-stall cycles
//   flush_cnt_HZD  : saturating count of redirect events
//
// state     | meaning
// ----------+-----------------------------------------------------------
// HZD_RUN   | normal issue; stalls on RAW, flushes on redirect
// HZD_FLUSH | post-redirect IF/ID bubbles, fl_cnt cycles left, RAW ignored
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int EXTRA_FLUSH = 0,
   parameter int CNT_W       = HZD_CNT_W_DEF
) (
   input  logic             clk_HZD,
   input  logic             rst_n_HZD,
   hazard_stall_ctrl_if.slave hzd,
   output logic [CNT_W-1:0] stall_cnt_HZD,
   output logic [CNT_W-1:0] flush_cnt_HZD
);

   localparam logic [1:0] FL_RELOAD = 2'(EXTRA_FLUSH);

   hzd_state_e state, state_nxt;
   logic [1:0] fl_cnt, fl_cnt_nxt;
   logic       hit_idex, hit_exmem, data_haz;
   logic       stall_inc, flush_inc;

   assign hit_idex = hzd.valid_IDEX_HZD & hzd.RegWrite_IDEX_HZD
                   & (hzd.Rd_IDEX_HZD != HZD_X0)
                   & ((hzd.Rs1_used_HZD & (hzd.Rd_IDEX_HZD == hzd.Rs1_addr_HZD))
                    | (hzd.Rs2_used_HZD & (hzd.Rd_IDEX_HZD == hzd.Rs2_addr_HZD)));

   assign hit_exmem = hzd.valid_EXMEM_HZD & hzd.RegWrite_EXMEM_HZD
                    & (hzd.Rd_EXMEM_HZD != HZD_X0)
                    & ((hzd.Rs1_used_HZD & (hzd.Rd_EXMEM_HZD == hzd.Rs1_addr_HZD))
                     | (hzd.Rs2_used_HZD & (hzd.Rd_EXMEM_HZD == hzd.Rs2_addr_HZD)));

   assign data_haz = hit_idex | hit_exmem;

   always_ff @(posedge clk_HZD or negedge rst_n_HZD) begin
      if (!rst_n_HZD) begin
         state  <= HZD_RUN;
         fl_cnt <= 2'd0;
      end else begin
         state  <= state_nxt;
         fl_cnt <= fl_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      fl_cnt_nxt        = fl_cnt;
      hzd.en_PC_HZD     = 1'b1;
      hzd.en_IFID_HZD   = 1'b1;
      hzd.NOP_IFID_HZD  = 1'b0;
      hzd.NOP_IDEX_HZD  = 1'b0;
      hzd.NOP_EXMEM_HZD = 1'b0;
      stall_inc         = 1'b0;
      flush_inc         = 1'b0;

      case (state)
         HZD_RUN: begin
            // redirect outranks a RAW stall: the stalled instruction is
            // on the wrong path anyway
            if (hzd.Redirect_HZD) begin
               hzd.NOP_IFID_HZD  = 1'b1;
               hzd.NOP_IDEX_HZD  = 1'b1;
               hzd.NOP_EXMEM_HZD = 1'b1;
               flush_inc         = 1'b1;
               if (EXTRA_FLUSH > 0) begin
                  state_nxt  = HZD_FLUSH;
                  fl_cnt_nxt = FL_RELOAD;
               end
            end else if (data_haz) begin
               hzd.en_PC_HZD    = 1'b0;
               hzd.en_IFID_HZD  = 1'b0;
               hzd.NOP_IDEX_HZD = 1'b1;
               stall_inc        = 1'b1;
            end
         end

         HZD_FLUSH: begin
            hzd.NOP_IFID_HZD = 1'b1;
            if (hzd.Redirect_HZD) begin
               hzd.NOP_IDEX_HZD  = 1'b1;
               hzd.NOP_EXMEM_HZD = 1'b1;
               flush_inc         = 1'b1;
               fl_cnt_nxt        = FL_RELOAD;
            end else begin
               fl_cnt_nxt = fl_cnt - 2'd1;
               if (fl_cnt == 2'd1) begin
                  state_nxt = HZD_RUN;
               end
            end
         end

         default: begin
            state_nxt  = HZD_RUN;
            fl_cnt_nxt = 2'd0;
         end
      endcase
   end

   hzd_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_HZD   (clk_HZD),
      .rst_n_HZD (rst_n_HZD),
      .inc       (stall_inc),
      .cnt       (stall_cnt_HZD)
   );

   hzd_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_HZD   (clk_HZD),
      .rst_n_HZD (rst_n_HZD),
      .inc       (flush_inc),
      .cnt       (flush_cnt_HZD)
   );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
// Two controllers share one stimulus stream: u_dut_a (EXTRA_FLUSH=2,
// CNT_W=4) and u_dut_b (defaults). Each step applies a directed input
// vector #1 after a rising edge and queues the hand-derived control
// outputs for both and the counters of u_dut_a; a monitor pops and
// compares on the falling edge.
module tb_hazard_stall_ctrl;

   localparam logic [4:0] C_RUN   = 5'b11000;  // {en_PC,en_IFID,NOP_IFID,NOP_IDEX,NOP_EXMEM}
   localparam logic [4:0] C_STALL = 5'b00010;
   localparam logic [4:0] C_REDIR = 5'b11111;
   localparam logic [4:0] C_FLUSH = 5'b11100;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic [4:0] rs1 = '0, rs2 = '0, rd1 = '0, rd2 = '0;
   logic       u1 = 0, u2 = 0, w1 = 0, v1 = 0, w2 = 0, v2 = 0, redir = 0;

   logic [3:0]  sc_a, fc_a;
   logic [15:0] sc_b, fc_b;

   hazard_stall_ctrl_if if_a ();
   hazard_stall_ctrl_if if_b ();

   assign if_a.Rs1_addr_HZD = rs1;        assign if_b.Rs1_addr_HZD = rs1;
   assign if_a.Rs2_addr_HZD = rs2;        assign if_b.Rs2_addr_HZD = rs2;
   assign if_a.Rs1_used_HZD = u1;         assign if_b.Rs1_used_HZD = u1;
   assign if_a.Rs2_used_HZD = u2;         assign if_b.Rs2_used_HZD = u2;
   assign if_a.Rd_IDEX_HZD = rd1;         assign if_b.Rd_IDEX_HZD = rd1;
   assign if_a.RegWrite_IDEX_HZD = w1;    assign if_b.RegWrite_IDEX_HZD = w1;
   assign if_a.valid_IDEX_HZD = v1;       assign if_b.valid_IDEX_HZD = v1;
   assign if_a.Rd_EXMEM_HZD = rd2;        assign if_b.Rd_EXMEM_HZD = rd2;
   assign if_a.RegWrite_EXMEM_HZD = w2;   assign if_b.RegWrite_EXMEM_HZD = w2;
   assign if_a.valid_EXMEM_HZD = v2;      assign if_b.valid_EXMEM_HZD = v2;
   assign if_a.Redirect_HZD = redir;      assign if_b.Redirect_HZD = redir;

   hazard_stall_ctrl #(.EXTRA_FLUSH(2), .CNT_W(4)) u_dut_a (
      .clk_HZD       (clk),
      .rst_n_HZD     (rst_n),
      .hzd           (if_a.slave),
      .stall_cnt_HZD (sc_a),
      .flush_cnt_HZD (fc_a)
   );

   hazard_stall_ctrl u_dut_b (
      .clk_HZD       (clk),
      .rst_n_HZD     (rst_n),
      .hzd           (if_b.slave),
      .stall_cnt_HZD (sc_b),
      .flush_cnt_HZD (fc_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] ca;
      logic [4:0] cb;
      logic [3:0] sc;
      logic [3:0] fc;
      string      nm;
   } exp_t;

   exp_t  sb[$];
   int    total = 0;
   int    bad = 0;
   int    stepn = 0;
   string tag = "init";

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.nm, " ctrl_a"}, {11'd0, if_a.en_PC_HZD, if_a.en_IFID_HZD,
                if_a.NOP_IFID_HZD, if_a.NOP_IDEX_HZD, if_a.NOP_EXMEM_HZD}, {11'd0, e.ca});
            chk({e.nm, " ctrl_b"}, {11'd0, if_b.en_PC_HZD, if_b.en_IFID_HZD,
                if_b.NOP_IFID_HZD, if_b.NOP_IDEX_HZD, if_b.NOP_EXMEM_HZD}, {11'd0, e.cb});
            chk({e.nm, " stall_cnt"}, {12'd0, sc_a}, {12'd0, e.sc});
            chk({e.nm, " flush_cnt"}, {12'd0, fc_a}, {12'd0, e.fc});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input logic rst,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic us1, input logic us2,
                       input logic [4:0] d1, input logic wr1, input logic vl1,
                       input logic [4:0] d2, input logic wr2, input logic vl2,
                       input logic rd_x,
                       input logic [4:0] ea, input logic [4:0] eb,
                       input int sc, input int fc);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst;
      rs1 = a1; rs2 = a2; u1 = us1; u2 = us2;
      rd1 = d1; w1 = wr1; v1 = vl1;
      rd2 = d2; w2 = wr2; v2 = vl2;
      redir = rd_x;
      e.ca = ea; e.cb = eb; e.sc = 4'(sc); e.fc = 4'(fc);
      e.nm = $sformatf("%s#%0d", tag, stepn);
      stepn++;
      sb.push_back(e);
   endtask

   task automatic idle(input logic [4:0] ea, input logic [4:0] eb, input int sc, input int fc);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb, sc, fc);
   endtask

   initial begin : stim
      tag = "reset";
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, C_RUN, 0, 0);
      idle(C_RUN, C_RUN, 0, 0);

      // lw x5 in ID/EX, add x6,x5,x1 in ID
      tag = "b2b";
      step(1, 5, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, C_STALL, C_STALL, 0, 0);
      step(1, 5, 1, 1, 1, 0, 0, 0, 5, 1, 1, 0, C_STALL, C_STALL, 1, 0);
      step(1, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, C_RUN, C_RUN, 2, 0);
      idle(C_RUN, C_RUN, 2, 0);

      tag = "nohaz";
      step(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, C_RUN, C_RUN, 2, 0);  // x0 in ID/EX
      step(1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, C_RUN, C_RUN, 2, 0);  // x0 in EX/MEM
      step(1, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, C_RUN, C_RUN, 2, 0);  // rs1 not used
      step(1, 5, 0, 1, 0, 5, 0, 1, 0, 0, 0, 0, C_RUN, C_RUN, 2, 0);  // no RegWrite
      step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, C_RUN, C_RUN, 2, 0);  // not valid

      tag = "rs2_exmem";
      step(1, 1, 7, 1, 1, 0, 0, 0, 7, 1, 1, 0, C_STALL, C_STALL, 2, 0);
      idle(C_RUN, C_RUN, 3, 0);

      tag = "redir";
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_REDIR, C_REDIR, 3, 0);
      idle(C_FLUSH, C_RUN, 3, 1);
      step(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, C_FLUSH, C_STALL, 3, 1);
      idle(C_RUN, C_RUN, 3, 1);

      tag = "redir_haz";
      step(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 1, C_REDIR, C_REDIR, 3, 1);
      idle(C_FLUSH, C_RUN, 3, 2);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_REDIR, C_REDIR, 3, 2);
      idle(C_FLUSH, C_RUN, 3, 3);
      idle(C_FLUSH, C_RUN, 3, 3);
      idle(C_RUN, C_RUN, 3, 3);

      tag = "sat";
      for (int i = 0; i < 20; i++) begin
         step(1, 9, 0, 1, 0, 0, 0, 0, 9, 1, 1, 0, C_STALL, C_STALL,
              (3 + i > 15) ? 15 : 3 + i, 3);
      end
      idle(C_RUN, C_RUN, 15, 3);

      // reset lands in the first flush cycle of u_dut_a (fl_cnt = 2)
      tag = "rst_flush";
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_REDIR, C_REDIR, 15, 3);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, C_RUN, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, C_RUN, 0, 0);
      idle(C_RUN, C_RUN, 0, 0);
      idle(C_RUN, C_RUN, 0, 0);
      idle(C_RUN, C_RUN, 0, 0);
      step(1, 9, 0, 1, 0, 0, 0, 0, 9, 1, 1, 0, C_STALL, C_STALL, 0, 0);
      idle(C_RUN, C_RUN, 1, 0);

      repeat (3) @(posedge clk);
      chk("sb_drain", 16'(sb.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It drives the `en_*`/`NOP_*` control pins of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects read-after-write data hazards and freezes the front end, inserting bubbles into ID/EX.
- On a taken branch or jump, redirects the PC and flushes the younger stages; the flush can optionally extend over extra cycles.
- Keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- `EXTRA_FLUSH`, default 0: additional cycles (0–3) that IF/ID is held in NOP after a redirect. Covers synchronous instruction memory latency.
- `CNT_W`, default 16: width of the event counters.

Ports (name, direction, width, meaning):
- `clk_HZD` in 1: core clock; all state updates on the rising edge.
- `rst_n_HZD` in 1: asynchronous, active-low reset.
- `Rs1_addr_HZD`, `Rs2_addr_HZD` in 5 each: source fields of the instruction in ID.
- `Rs1_used_HZD`, `Rs2_used_HZD` in 1 each: the ID instruction actually reads rs1/rs2.
- `Rd_IDEX_HZD` in 5, `RegWrite_IDEX_HZD` in 1, `valid_IDEX_HZD` in 1: state of the ID/EX register outputs.
- `Rd_EXMEM_HZD` in 5, `RegWrite_EXMEM_HZD` in 1, `valid_EXMEM_HZD` in 1: state of the EX/MEM register outputs.
- `Redirect_HZD` in 1: taken branch or jump, resolved in the MEM stage (EX/MEM outputs).
- `en_PC_HZD` out 1: PC write enable.
- `en_IFID_HZD` out 1: IF/ID enable.
- `NOP_IFID_HZD`, `NOP_IDEX_HZD`, `NOP_EXMEM_HZD` out 1 each: bubble insert for each register.
- `stall_cnt_HZD` out CNT_W: count of data-stall cycles.
- `flush_cnt_HZD` out CNT_W: count of redirect events.

## Operation
The core has no forwarding. The register file is write-first, so MEM/WB is never checked.

Hazard terms:
- `hitX` = valid_X & RegWrite_X & (Rd_X != 0) & ((Rs1_used & Rd_X == Rs1_addr) | (Rs2_used & Rd_X == Rs2_addr)), for X ∈ {IDEX, EXMEM}.
- `data_haz` = hitIDEX | hitEXMEM.

FSM states: RUN, FLUSH. A down-counter `fl_cnt` (2 bits) tracks remaining extra flush cycles.

RUN:
- **Redirect_HZD = 1** (highest priority): en_PC = 1, en_IFID = 1, NOP_IFID = NOP_IDEX = NOP_EXMEM = 1, flush_cnt += 1.
  - If EXTRA_FLUSH > 0: go to FLUSH with fl_cnt = EXTRA_FLUSH.
- **data_haz = 1**: en_PC = 0, en_IFID = 0, NOP_IDEX = 1, all other NOP = 0, stall_cnt += 1. Stay in RUN.
- **Otherwise**: en_PC = en_IFID = 1, all NOP = 0.

FLUSH:
- en_PC = 1, en_IFID = 1, NOP_IFID = 1, NOP_IDEX = NOP_EXMEM = 0.
- data_haz is ignored.
- fl_cnt decrements each cycle; leave for RUN on the cycle fl_cnt = 1.
- If Redirect_HZD = 1 in FLUSH: behave as a RUN redirect (all three NOPs, flush_cnt += 1) and reload fl_cnt = EXTRA_FLUSH.

Counters:
- Saturate at all-ones and never wrap.
- Increment only when the corresponding condition holds at a rising edge with reset deasserted.

## Timing
- Control outputs are combinational (Mealy) from the current inputs plus the FSM state. The bubble or hold takes effect at the same rising edge at which the pipeline registers sample them.
- State, fl_cnt and the counters are registered.
- A RAW stall lasts until the producer leaves EX/MEM:
  - 2 cycles when the producer is in ID/EX.
  - 1 cycle when it is in EX/MEM.
- A redirect costs 3 bubbles plus EXTRA_FLUSH additional IF/ID bubbles.
- Reset asserted (asynchronous, at any time, including mid-FLUSH): state = RUN, fl_cnt = 0, counters = 0. Combinational outputs then read en_PC = en_IFID = 1 and all NOP = 0.
- After rst_n_HZD deasserts, normal operation begins at the first rising edge.
- Redirect and data_haz in the same cycle: the redirect wins and stall_cnt does not increment.
- Rd = x0 never causes a stall.

## Structure
- Shared pipeline package holds:
  - `HZD_RUN` / `HZD_FLUSH` state encodings (1 bit).
  - The x0 address constant.
  - The `CNT_W` default.
- A natural sub-module is `hzd_sat_counter`: a parameterised saturating counter with an increment enable and asynchronous active-low reset, instantiated twice.
- RAW comparison stays inline.

## Test plan
- **Back-to-back dependency** (`lw x5` in ID/EX, `add x6,x5,x1` in ID): 2 cycles of en_PC = 0, en_IFID = 0, NOP_IDEX = 1, then release; stall_cnt = 2.
- **Write to x0** (Rd_IDEX = 0, RegWrite = 1, Rs1 = 0 used): no stall, stall_cnt stays 0.
- **Redirect with EXTRA_FLUSH = 2**: cycle 0 has all three NOPs and en_PC = 1; cycles 1–2 have only NOP_IFID = 1; cycle 3 is RUN; flush_cnt = 1.
- **Redirect and hitIDEX in the same cycle**: flush outputs only, stall_cnt unchanged, en_PC = 1.
- **Saturation** with CNT_W = 4 under 20 continuous stall cycles: stall_cnt holds at 15.
- **rst_n_HZD pulled low mid-FLUSH** (fl_cnt = 2): outputs return immediately to en = 1 / NOP = 0; counters read 0; no residual NOP_IFID after reset release.
